// File: rtl/cmp_eq_arbiter.sv
// cmp_eq_arbiter: round-robin arbiter sharing one 8-bit equality comparator
// among NUM_REQ requesters. Grant, compare, then a one-cycle ack/response.

// Basic combinational 8-bit equality comparator.
module comparator_8bit_equal_basic (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_eq_b
);

  // Equality of the two operands.
  assign a_eq_b = (a == b);

endmodule

module cmp_eq_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   a_in,
  input  logic [8*NUM_REQ-1:0]   b_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   eq_out,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy
);

  localparam int unsigned OP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [OP_W-1:0]      r_a;
  logic [OP_W-1:0]      r_b;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_eq;
  logic [GID_W-1:0]     r_grant_id;
  logic [GID_W-1:0]     r_last_grant;
  logic                 r_busy;
  logic                 w_a_eq_b;
  logic                 w_found;
  logic [GID_W-1:0]     w_winner;

  // First set request searching upward from last_grant+1 with wrap-around.
  function automatic logic [GID_W:0] pick_winner(
    input logic [NUM_REQ-1:0] rq,
    input logic [GID_W-1:0]   last
  );
    logic             found;
    logic [GID_W-1:0] win;
    int               idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last) + k) % int'(NUM_REQ);
      if (!found && rq[GID_W'(idx)]) begin
        found = 1'b1;
        win   = GID_W'(idx);
      end
    end
    return {found, win};
  endfunction

  // Round-robin selection from the live request vector.
  assign {w_found, w_winner} = pick_winner(req, r_last_grant);

  // Shared comparator, fed only from the latched operands.
  comparator_8bit_equal_basic u_cmp (
    .a      (r_a),
    .b      (r_b),
    .a_eq_b (w_a_eq_b)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: grant in IDLE, compare, then one response cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = CMP;
      CMP:     w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered datapath and outputs; last_grant resets so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_ack        <= '0;
      r_eq         <= 1'b0;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a          <= a_in[OP_W*int'(w_winner) +: OP_W];
            r_b          <= b_in[OP_W*int'(w_winner) +: OP_W];
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        CMP: begin
          r_eq  <= w_a_eq_b;
          r_ack <= NUM_REQ'(1) << r_grant_id;
        end
        RESP: begin
          r_ack <= '0;
        end
        default: begin
          r_ack <= '0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign eq_out   = r_eq;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule
